// File: rtl/mm_job_arbiter.sv
// rtl/mm_job_arbiter.sv - round-robin job arbiter sharing one matrix-multiply engine among NUM_REQ requesters
// Optional busy watchdog enabled by defining MM_ARB_TIMEOUT_EN.
module mm_job_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter int          ID_W        = 2,
  parameter logic [15:0] TIMEOUT_CYC = 16'd40000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] req_done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    owner,
  output logic               busy,
  output logic               eng_start,
  input  logic               eng_done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] idx;
  logic            pick_valid;
  logic            timeout;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

`ifdef MM_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  assign cnt_inc = cnt + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == START) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt_inc;
    end
  end

  // Fires on the BUSY cycle where the count steps to TIMEOUT_CYC-1.
  assign timeout = (state == BUSY) && (cnt_inc == TIMEOUT_CYC - 16'd1);
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = START;
      START:   state_nxt = BUSY;
      BUSY:    if (eng_done || timeout) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      req_done  <= '0;
      err       <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      eng_start <= (state == IDLE) && pick_valid;
      req_done  <= '0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= NUM_REQ'(1) << pick;
            owner <= pick;
          end
        end
        BUSY: begin
          if (eng_done || timeout) begin
            req_done <= gnt;
            err      <= timeout && !eng_done;
          end
        end
        RELEASE: begin
          gnt    <= '0;
          rr_ptr <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_job_arbiter.sv
// tb/tb_mm_job_arbiter.sv - directed self-checking bench for mm_job_arbiter
module tb_mm_job_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic               clk      = 1'b0;
  logic               reset_n  = 1'b0;
  logic [NUM_REQ-1:0] req      = '0;
  logic               eng_done = 1'b0;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    owner;
  logic               busy;
  logic               eng_start;
  logic               err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mm_job_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W),
    .TIMEOUT_CYC(16'd10)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_done (req_done),
    .gnt      (gnt),
    .owner    (owner),
    .busy     (busy),
    .eng_start(eng_start),
    .eng_done (eng_done),
    .err      (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n  = 1'b0;
    req      = '0;
    eng_done = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Issues req=r, answers the start after dly cycles, drops the finished bit, returns at done+2.
  task automatic run_job(input logic [3:0] r, input int dly, output logic [1:0] o,
                         output logic [3:0] g, output logic [3:0] d,
                         output logic after_busy, output logic [3:0] after_done, output bit ok);
    ok = 1'b0; o = '0; g = '0; d = '0; after_busy = 1'b1; after_done = '1;
    req = r;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (eng_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      req = '0;
      return;
    end
    o = owner;
    g = gnt;
    repeat (dly) tick();
    eng_done = 1'b1;
    tick();
    eng_done   = 1'b0;
    d          = req_done;
    req        = req & ~req_done;
    tick();
    after_busy = busy;
    after_done = req_done;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    n_checks++;
    if ({gnt, owner, busy, eng_start, req_done, err} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {gnt, owner, busy, eng_start, req_done, err});
    end
    do_reset();
  endtask

  task automatic test_single_job;
    logic [11:0] exp_v;
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 22; c++) begin
      tick();
      exp_v = {(c <= 21) ? 4'b0010 : 4'b0000, 2'd1, 1'(c <= 21), 1'(c == 1),
               (c == 21) ? 4'b0010 : 4'b0000};
      n_checks++;
      if ({gnt, owner, busy, eng_start, req_done} !== exp_v) begin
        n_fail++;
        $display("FAIL single_job cycle %0d: got {gnt,owner,busy,start,done}=%h expected %h",
                 c, {gnt, owner, busy, eng_start, req_done}, exp_v);
      end
      eng_done = (c == 20);
      if (c == 21) req = '0;
    end
  endtask

  task automatic test_round_robin;
    int exp_o[5] = '{0, 1, 2, 3, 0};
    logic [1:0] o;
    logic [3:0] g, d, ad, e1;
    logic ab;
    bit ok;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      run_job(4'b1111, 5, o, g, d, ab, ad, ok);
      e1 = 4'b0001 << exp_o[j];
      n_checks++;
      if (!ok || o !== ID_W'(exp_o[j]) || g !== e1 || d !== e1 || ad !== 4'b0000 || ab !== 1'b0) begin
        n_fail++;
        $display("FAIL round_robin job %0d: got ok=%0d owner=%0d gnt=%b done=%b after_done=%b after_busy=%b expected owner=%0d gnt/done=%b",
                 j, ok, o, g, d, ad, ab, exp_o[j], e1);
      end
    end
    req = '0;
  endtask

  task automatic test_wrap_skip;
    logic [1:0] o;
    logic [3:0] g, d, ad;
    logic ab;
    bit ok;
    do_reset();
    run_job(4'b0100, 3, o, g, d, ab, ad, ok);
    n_checks++;
    if (!ok || o !== 2'd2 || d !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_setup: got ok=%0d owner=%0d done=%b expected owner=2 done=0100", ok, o, d);
    end
    run_job(4'b0101, 3, o, g, d, ab, ad, ok);
    n_checks++;
    if (!ok || o !== 2'd0 || g !== 4'b0001 || d !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_first: got ok=%0d owner=%0d gnt=%b done=%b expected owner=0", ok, o, g, d);
    end
    run_job(4'b0100, 3, o, g, d, ab, ad, ok);
    n_checks++;
    if (!ok || o !== 2'd2 || g !== 4'b0100 || d !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_second: got ok=%0d owner=%0d gnt=%b done=%b expected owner=2", ok, o, g, d);
    end
  endtask

  task automatic test_spurious_and_drop;
    do_reset();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({gnt, busy, eng_start, req_done} !== 10'h0) begin
        n_fail++;
        $display("FAIL done_in_idle cycle %0d: got %h expected 0", c, {gnt, busy, eng_start, req_done});
      end
      tick();
    end
    req = 4'b1000;
    tick();
    n_checks++;
    if (eng_start !== 1'b1 || gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL start_cycle: got start=%b gnt=%b expected 1 1000", eng_start, gnt);
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    n_checks++;
    if ({busy, eng_start, req_done, gnt} !== {1'b1, 1'b0, 4'b0000, 4'b1000}) begin
      n_fail++;
      $display("FAIL done_in_start: got {busy,start,done,gnt}=%b expected 1_0_0000_1000",
               {busy, eng_start, req_done, gnt});
    end
    tick();
    req = '0;
    repeat (3) tick();
    n_checks++;
    if ({busy, req_done, gnt} !== {1'b1, 4'b0000, 4'b1000}) begin
      n_fail++;
      $display("FAIL drop_still_busy: got {busy,done,gnt}=%b expected 1_0000_1000", {busy, req_done, gnt});
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    n_checks++;
    if (req_done !== 4'b1000) begin
      n_fail++;
      $display("FAIL drop_req_done: got %b expected 1000", req_done);
    end
    tick();
    n_checks++;
    if ({busy, gnt, owner} !== {1'b0, 4'b0000, 2'd3}) begin
      n_fail++;
      $display("FAIL drop_back_idle: got {busy,gnt,owner}=%b expected 0_0000_11", {busy, gnt, owner});
    end
  endtask

  task automatic test_reset_mid_job;
    logic [1:0] o;
    logic [3:0] g, d, ad;
    logic ab;
    bit ok;
    bit seen;
    bit stray;
    do_reset();
    run_job(4'b0010, 2, o, g, d, ab, ad, ok);
    req = 4'b0100;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1 || owner !== 2'd2) begin
      n_fail++;
      $display("FAIL midjob_setup: got busy=%b owner=%0d expected 1 2", busy, owner);
    end
    req     = 4'b1001;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, owner, busy, eng_start, req_done, err} !== 15'h0) begin
      n_fail++;
      $display("FAIL midjob_async_clear: got %h expected 0", {gnt, owner, busy, eng_start, req_done, err});
    end
    tick();
    tick();
    reset_n = 1'b1;
    seen    = 1'b0;
    stray   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_done !== 4'b0000) stray = 1'b1;
      if (eng_start) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || stray || owner !== 2'd0 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL midjob_regrant: got seen=%0d stray_done=%0d owner=%0d gnt=%b expected 1 0 0 0001",
               seen, stray, owner, gnt);
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    req      = '0;
    tick();
    tick();
  endtask

`ifdef MM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [5:0] exp_v;
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_v = {(c == 11) ? 4'b0001 : 4'b0000, 1'(c == 11), 1'(c <= 11)};
      n_checks++;
      if ({req_done, err, busy} !== exp_v) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got {done,err,busy}=%b expected %b", c, {req_done, err, busy}, exp_v);
      end
      if (c == 11) req = '0;
    end
    req = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_v = {(c == 11) ? 4'b0010 : 4'b0000, 1'b0, 1'(c <= 11)};
      n_checks++;
      if ({req_done, err, busy} !== exp_v) begin
        n_fail++;
        $display("FAIL timeout_vs_done cycle %0d: got {done,err,busy}=%b expected %b",
                 c, {req_done, err, busy}, exp_v);
      end
      eng_done = (c == 10);
      if (c == 11) req = '0;
    end
  endtask
`else
  task automatic test_timeout;
    bit bad;
    do_reset();
    req = 4'b0001;
    bad = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (err !== 1'b0 || busy !== 1'b1 || req_done !== 4'b0000) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL no_watchdog: got early release or err over 40 busy cycles expected steady busy");
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    n_checks++;
    if (req_done !== 4'b0001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_watchdog_done: got done=%b err=%b expected 0001 0", req_done, err);
    end
    req = '0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_wrap_skip();
    test_spurious_and_drop();
    test_reset_mid_job();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_job_arbiter.md
Name: mm_job_arbiter

Overview:
- Round-robin scheduler that shares one matrix-multiply engine (16x49 · 49x32, start/done handshake) between NUM_REQ requesters.
- Selects the next requester and drives its memory-bank select so the engine's A/B/C ports route to that requester's buffers.
- Pulses the engine start, waits for engine done, returns a per-requester completion pulse.
- Sits between the job-issuing masters and the engine plus its memory mux.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of owner index; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT_CYC, 16'd40000, watchdog limit in cycles; used only with MM_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester job request, level; held until its req_done.
- req_done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
- gnt  output  NUM_REQ  one-hot grant; high from grant through release.
- owner  output  ID_W  index of current/last owner; drives the bank mux select.
- busy  output  1  high whenever state is not IDLE.
- eng_start  output  1  one-cycle start pulse to the engine.
- eng_done  input  1  one-cycle done pulse from the engine.
- err  output  1  one-cycle timeout pulse; tied 0 without MM_ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While reset_n=0, all outputs are 0 and the round-robin pointer rr_ptr is 0.
- Reset mid-job: returns to IDLE at once. No req_done is issued. The engine is reset by its own reset.
- All outputs are registered.
- State IDLE:
  - If any req bit is set, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register gnt one-hot and owner, then go to START.
  - If no req bit is set, stay in IDLE.
- State START (one cycle):
  - eng_start=1, gnt/owner/busy held.
  - Go to BUSY.
- State BUSY:
  - Wait for eng_done=1, then go to RELEASE.
  - req deassertion by the owner is ignored; the job runs to completion.
- State RELEASE (one cycle):
  - req_done[owner]=1.
  - rr_ptr <= owner+1, wrapping NUM_REQ-1 to 0.
  - Go to IDLE. gnt clears on entering IDLE; owner keeps its last value.
- Latency: req sampled high in IDLE at cycle 0 gives gnt/busy at cycle 1 and eng_start at cycle 1 only. eng_done at cycle N gives req_done at cycle N+1 and IDLE at N+2. Next grant is earliest at N+3.
- eng_done outside BUSY (including in START) is ignored and does not change state.
- Simultaneous eng_done and new req edges: the new requests wait for the next IDLE arbitration.
- Fairness: a continuously requesting master waits at most NUM_REQ-1 jobs.
- req bits at positions >= NUM_REQ do not exist. Out-of-range owner values never occur.

Optional Feature:
- Macro: MM_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears in START and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYC-1 without eng_done, go to RELEASE and pulse err=1 in the same cycle as req_done[owner]=1.
  - If eng_done arrives on that same cycle, it takes priority: no err.
- When undefined:
  - No counter exists and err is constant 0.
  - BUSY waits indefinitely.

Test Plan:
- Single job: req=4'b0010 at cycle 0; eng_done at cycle 20.
  - Expect gnt=4'b0010, owner=1, eng_start high only at cycle 1, req_done=4'b0010 at cycle 21, busy low at cycle 22.
- Round-robin: req=4'b1111 held; engine answers each start after 5 cycles.
  - Expect grant order 0,1,2,3,0, with exactly one req_done per job.
- Wrap and skip: rr_ptr=3 with req=4'b0101.
  - Expect grant to 0, then 2.
- Spurious done and early drop:
  - eng_done pulsed in IDLE and in START → no state change.
  - Owner drops req in BUSY → req_done still pulses after eng_done.
- Reset mid-job: reset_n low during BUSY for 2 cycles.
  - Expect all outputs 0 immediately, no req_done, and the next grant goes to the lowest set req bit (rr_ptr=0).
- With MM_ARB_TIMEOUT_EN and TIMEOUT_CYC=10, engine never answers.
  - Expect err=1 and req_done[owner]=1 in the same cycle, 10 cycles after START, then IDLE.
  - Repeat with eng_done on that cycle → err=0.
